// File: rtl/mantissa_normalizer_pkg.sv
// rtl/mantissa_normalizer_pkg.sv - shared FPU constants, FSM state encoding and width helper
// Contents:
//   DEF_MANT_W / DEF_EXP_W : default mantissa and biased-exponent widths
//   state_t                : normalizer FSM encoding (IDLE must stay 0 so reset clears it)
//   max_int                : constant helper for sizing comparison datapaths
package mantissa_normalizer_pkg;

    localparam int DEF_MANT_W = 24;
    localparam int DEF_EXP_W  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DETECT = 2'd1,
        SHIFT  = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mantissa_normalizer_if.sv
// rtl/mantissa_normalizer_if.sv - request/result bundle between a requester and the normalizer
// Signals:
//   start, mant_in, exp_in                       : request (driven by master)
//   busy, done, mant_out, exp_out, zero, underflow : status/result (driven by slave)
// Modports: master = requester side, slave = normalizer side.
interface mantissa_normalizer_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              start;
    logic [MANT_W-1:0] mant_in;
    logic [EXP_W-1:0]  exp_in;
    logic              busy;
    logic              done;
    logic [MANT_W-1:0] mant_out;
    logic [EXP_W-1:0]  exp_out;
    logic              zero;
    logic              underflow;

    modport master (
        output start, mant_in, exp_in,
        input  busy, done, mant_out, exp_out, zero, underflow
    );

    modport slave (
        input  start, mant_in, exp_in,
        output busy, done, mant_out, exp_out, zero, underflow
    );
endinterface

// File: rtl/mantissa_normalizer_first_one_finder.sv
// rtl/mantissa_normalizer_first_one_finder.sv - one-hot marker of the highest set bit
// Ports:
//   in_i        : SIZE-bit input vector
//   max_power_o : one-hot with only the most significant set bit of in_i; all zero if in_i is zero
module first_one_finder #(
    parameter int SIZE = 24
) (
    input  logic [SIZE-1:0] in_i,
    output logic [SIZE-1:0] max_power_o
);
    // Scan upward; each set bit replaces the previous marker so the highest one survives.
    always_comb begin
        max_power_o = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (in_i[i]) begin
                max_power_o    = '0;
                max_power_o[i] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mantissa_normalizer.sv
// rtl/mantissa_normalizer.sv - multi-cycle mantissa normalizer with exponent-clamped left shift
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : mantissa_normalizer_if.slave (start/mant_in/exp_in in; busy/done/mant_out/exp_out/zero/underflow out)
// Flow: IDLE captures on start, DETECT finds the leading one, SHIFT registers the
// result, DONE pulses done for one cycle.
module mantissa_normalizer
    import mantissa_normalizer_pkg::*;
#(
    parameter int MANT_W = DEF_MANT_W,
    parameter int EXP_W  = DEF_EXP_W
) (
    input logic                  clk,
    input logic                  rst,
    mantissa_normalizer_if.slave bus
);
    localparam int IDX_W = (MANT_W > 1) ? $clog2(MANT_W) : 1;
    // Common width so the shift amount and the exponent compare without truncation.
    localparam int CMP_W = max_int(IDX_W, EXP_W);

    state_t            state_q, state_d;
    logic [MANT_W-1:0] mant_q, mant_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic [IDX_W-1:0]  shift_q, shift_d;
    logic              in_zero_q, in_zero_d;
    logic [MANT_W-1:0] mant_out_q, mant_out_d;
    logic [EXP_W-1:0]  exp_out_q, exp_out_d;
    logic              zero_q, zero_d;
    logic              underflow_q, underflow_d;
    logic              done_q, done_d;

    logic [MANT_W-1:0] max_power;
    logic [IDX_W-1:0]  lead_idx;
    logic [CMP_W-1:0]  shift_ext, exp_ext, eff_shift;
    logic              clamp;

    first_one_finder #(.SIZE(MANT_W)) u_first_one_finder (
        .in_i        (mant_q),
        .max_power_o (max_power)
    );

    // One-hot to binary index of the leading one.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < MANT_W; i++) begin
            if (max_power[i]) begin
                lead_idx = lead_idx | IDX_W'(i);
            end
        end
    end

    // Clamp the shift so the exponent never goes below zero.
    always_comb begin
        shift_ext = CMP_W'(shift_q);
        exp_ext   = CMP_W'(exp_q);
        clamp     = (shift_ext > exp_ext);
        eff_shift = clamp ? exp_ext : shift_ext;
    end

    always_comb begin
        state_d     = state_q;
        mant_d      = mant_q;
        exp_d       = exp_q;
        shift_d     = shift_q;
        in_zero_d   = in_zero_q;
        mant_out_d  = mant_out_q;
        exp_out_d   = exp_out_q;
        zero_d      = zero_q;
        underflow_d = underflow_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mant_d  = bus.mant_in;
                    exp_d   = bus.exp_in;
                    state_d = DETECT;
                end
            end
            DETECT: begin
                shift_d   = IDX_W'(MANT_W - 1) - lead_idx;
                in_zero_d = (mant_q == '0);
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (in_zero_q) begin
                    mant_out_d  = '0;
                    exp_out_d   = '0;
                    zero_d      = 1'b1;
                    underflow_d = 1'b0;
                end else begin
                    mant_out_d  = mant_q << eff_shift;
                    exp_out_d   = exp_q - EXP_W'(eff_shift);
                    zero_d      = 1'b0;
                    underflow_d = clamp;
                end
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mant_q      <= '0;
            exp_q       <= '0;
            shift_q     <= '0;
            in_zero_q   <= 1'b0;
            mant_out_q  <= '0;
            exp_out_q   <= '0;
            zero_q      <= 1'b0;
            underflow_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            shift_q     <= shift_d;
            in_zero_q   <= in_zero_d;
            mant_out_q  <= mant_out_d;
            exp_out_q   <= exp_out_d;
            zero_q      <= zero_d;
            underflow_q <= underflow_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.mant_out  = mant_out_q;
    assign bus.exp_out   = exp_out_q;
    assign bus.zero      = zero_q;
    assign bus.underflow = underflow_q;
endmodule
